// File: rtl/zap_copro_responder.sv
// CP15-style system coprocessor on the decode-stage copro interface.
// Handles MCR/MRC against 16 CP registers and returns a one-cycle done pulse.
module zap_copro_responder #(
  parameter int          PHY_REGS = 46,
  parameter int          CP_NUM   = 15,
  parameter logic [31:0] ID_VALUE = 32'h4107_0000
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_copro_dav,
  input  logic [31:0]                 i_copro_word,
  input  logic [$clog2(PHY_REGS)-1:0] i_copro_reg,
  output logic                        o_copro_done,
  output logic                        o_copro_und,
  output logic                        o_reg_rd_en,
  output logic [$clog2(PHY_REGS)-1:0] o_reg_rd_addr,
  input  logic [31:0]                 i_reg_rd_data,
  output logic                        o_reg_wr_en,
  output logic [$clog2(PHY_REGS)-1:0] o_reg_wr_addr,
  output logic [31:0]                 o_reg_wr_data,
  output logic [31:0]                 o_cr1_ff
);

  localparam int AW = $clog2(PHY_REGS);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_CAP, S_WB, S_DONE, S_DROP
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      crn_q, crn_d;
  logic [AW-1:0]   reg_q, reg_d;
  logic            und_q, und_d;
  logic [31:0]     cr_q [16];

  logic            rd_en_d, wr_en_d, done_d, und_out_d;
  logic [AW-1:0]   rd_addr_d, wr_addr_d;
  logic [31:0]     wr_data_d;

  logic            sup, is_mrc;
  logic            unused_word;

  assign sup = (i_copro_word[27:24] == 4'b1110) &&
               i_copro_word[4] &&
               (i_copro_word[11:8] == 4'(CP_NUM));
  assign is_mrc = i_copro_word[20];
  assign unused_word = ^{i_copro_word[31:28], i_copro_word[23:21],
                         i_copro_word[15:12], i_copro_word[7:5],
                         i_copro_word[3:0]};

  // State, transaction latches and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= S_IDLE;
      crn_q         <= '0;
      reg_q         <= '0;
      und_q         <= 1'b0;
      o_reg_rd_en   <= 1'b0;
      o_reg_rd_addr <= '0;
      o_reg_wr_en   <= 1'b0;
      o_reg_wr_addr <= '0;
      o_reg_wr_data <= '0;
      o_copro_done  <= 1'b0;
      o_copro_und   <= 1'b0;
    end else begin
      state_q       <= state_d;
      crn_q         <= crn_d;
      reg_q         <= reg_d;
      und_q         <= und_d;
      o_reg_rd_en   <= rd_en_d;
      o_reg_rd_addr <= rd_addr_d;
      o_reg_wr_en   <= wr_en_d;
      o_reg_wr_addr <= wr_addr_d;
      o_reg_wr_data <= wr_data_d;
      o_copro_done  <= done_d;
      o_copro_und   <= und_out_d;
    end
  end

  // Next state; the request is decoded and latched once, in IDLE.
  always_comb begin
    state_d = state_q;
    crn_d   = crn_q;
    reg_d   = reg_q;
    und_d   = und_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_copro_dav) begin
          crn_d = i_copro_word[19:16];
          reg_d = i_copro_reg;
          und_d = !sup;
          if (!sup)        state_d = S_DONE;
          else if (is_mrc) state_d = S_WB;
          else             state_d = S_RD;
        end
      end
      S_RD:   state_d = S_CAP;
      S_CAP:  state_d = S_DONE;
      S_WB:   state_d = S_DONE;
      S_DONE: state_d = S_DROP;
      S_DROP: if (!i_copro_dav) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave a flop.
  always_comb begin
    rd_en_d   = (state_d == S_RD);
    wr_en_d   = (state_d == S_WB);
    done_d    = (state_d == S_DONE);
    und_out_d = done_d && und_d;
    rd_addr_d = rd_en_d ? reg_d : o_reg_rd_addr;
    wr_addr_d = wr_en_d ? reg_d : o_reg_wr_addr;
    wr_data_d = wr_en_d ? cr_q[crn_d] : o_reg_wr_data;
  end

  // CP register file; CR0 is a fixed ID and ignores writes.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cr_q[0] <= ID_VALUE;
      for (int i = 1; i < 16; i++) cr_q[i] <= '0;
    end else if (state_q == S_CAP && crn_q != 4'd0) begin
      cr_q[crn_q] <= i_reg_rd_data;
    end
  end

  assign o_cr1_ff = cr_q[1];

endmodule

// File: tb/tb_zap_copro_responder.sv
// Randomised and directed bench for zap_copro_responder.
// Reference model tracks CP registers and the CPU register file.
module tb_zap_copro_responder;

  localparam int AW = $clog2(46);
  localparam logic [31:0] ID = 32'h4107_0000;

  logic          clk = 0;
  logic          rst = 0;
  logic          dav = 0;
  logic [31:0]   word = 0;
  logic [AW-1:0] creg = 0;
  logic          done, und, rd_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [31:0]   rdata = 0;
  logic [31:0]   wr_data, cr1;

  zap_copro_responder dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_copro_dav   (dav),
    .i_copro_word  (word),
    .i_copro_reg   (creg),
    .o_copro_done  (done),
    .o_copro_und   (und),
    .o_reg_rd_en   (rd_en),
    .o_reg_rd_addr (rd_addr),
    .i_reg_rd_data (rdata),
    .o_reg_wr_en   (wr_en),
    .o_reg_wr_addr (wr_addr),
    .o_reg_wr_data (wr_data),
    .o_cr1_ff      (cr1)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] rf [46];
  logic [31:0] mcr [16];

  int          o_done_cnt, o_done_cyc, o_rd_cnt, o_rd_cyc;
  int          o_wr_cnt, o_wr_cyc;
  logic        o_und, o_both;
  logic [AW-1:0] o_rd_addr, o_wr_addr;
  logic [31:0] o_wr_data, o_cr1;

  task automatic model_reset();
    mcr[0] = ID;
    for (int i = 1; i < 16; i++) mcr[i] = 0;
  endtask

  // Reference: apply one request to the model.
  task automatic model_apply(input logic [31:0] w, input int r,
                             output bit s, output bit m,
                             output logic [31:0] rv);
    int n;
    s = (w[27:24] == 4'hE) && w[4] && (w[11:8] == 4'd15);
    m = w[20];
    n = int'(w[19:16]);
    rv = mcr[n];
    if (s && !m && n != 0) mcr[n] = rf[r];
  endtask

  // Drive one request and record what the DUT did, cycle by cycle.
  task automatic run_txn(input logic [31:0] w, input logic [AW-1:0] r,
                         input int hold, input bit early);
    bit prev_rd;
    logic [AW-1:0] prev_addr;
    o_done_cnt = 0; o_done_cyc = -1; o_rd_cnt = 0; o_rd_cyc = -1;
    o_wr_cnt = 0; o_wr_cyc = -1; o_und = 0; o_both = 0;
    o_rd_addr = 0; o_wr_addr = 0; o_wr_data = 0; o_cr1 = 0;
    prev_rd = 0; prev_addr = 0;
    word = w; creg = r; dav = 1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (prev_rd) rdata = rf[prev_addr];
      else rdata = $urandom;
      prev_rd = rd_en; prev_addr = rd_addr;
      if (rd_en) begin
        o_rd_cnt++; o_rd_cyc = c; o_rd_addr = rd_addr;
      end
      if (wr_en) begin
        o_wr_cnt++; o_wr_cyc = c; o_wr_addr = wr_addr;
        o_wr_data = wr_data;
        if (int'(wr_addr) < 46) rf[wr_addr] = wr_data;
      end
      if (rd_en && wr_en) o_both = 1;
      if (done) begin
        o_done_cnt++;
        if (o_done_cyc < 0) begin
          o_done_cyc = c; o_und = und;
        end
      end
      if (o_done_cyc >= 0 && c == o_done_cyc + 1) o_cr1 = cr1;
      if (early && c == 1) dav = 0;
      if (o_done_cyc >= 0 && c == o_done_cyc + hold) dav = 0;
      if (o_done_cyc >= 0 && c == o_done_cyc + hold + 2) break;
    end
    dav = 0;
  endtask

  task automatic test_reset();
    rst = 1; dav = 0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({done, und, rd_en, wr_en} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_strobes got %b want 0000",
               {done, und, rd_en, wr_en});
    end
    n_tests++;
    if ({rd_addr, wr_addr, wr_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_addr_data got %h/%h/%h want 0",
               rd_addr, wr_addr, wr_data);
    end
    n_tests++;
    if (cr1 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_cr1 got %h want 0", cr1);
    end
    rst = 0;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_mcr();
    bit s, m; logic [31:0] rv;
    rf[6] = 32'h0000_1005;
    model_apply(32'hEE01_0F10, 6, s, m, rv);
    run_txn(32'hEE01_0F10, 6, 0, 0);
    n_tests++;
    if (o_rd_cnt !== 1 || o_rd_cyc !== 1 || o_rd_addr !== 6) begin
      n_fail++;
      $display("FAIL mcr_rd got cnt=%0d cyc=%0d addr=%0d want 1/1/6",
               o_rd_cnt, o_rd_cyc, o_rd_addr);
    end
    n_tests++;
    if (o_done_cnt !== 1 || o_done_cyc !== 3 || o_und !== 0) begin
      n_fail++;
      $display("FAIL mcr_done got cnt=%0d cyc=%0d und=%b want 1/3/0",
               o_done_cnt, o_done_cyc, o_und);
    end
    n_tests++;
    if (o_cr1 !== 32'h0000_1005) begin
      n_fail++;
      $display("FAIL mcr_cr1 got %h want 00001005", o_cr1);
    end
    n_tests++;
    if (o_wr_cnt !== 0) begin
      n_fail++;
      $display("FAIL mcr_no_wr got %0d want 0", o_wr_cnt);
    end
  endtask

  task automatic test_mrc_readback();
    bit s, m; logic [31:0] rv;
    model_apply(32'hEE11_0F10, 9, s, m, rv);
    run_txn(32'hEE11_0F10, 9, 0, 0);
    n_tests++;
    if (o_wr_cnt !== 1 || o_wr_cyc !== 1 || o_wr_addr !== 9 ||
        o_wr_data !== 32'h0000_1005) begin
      n_fail++;
      $display("FAIL mrc_wr got cnt=%0d cyc=%0d addr=%0d data=%h want 1/1/9/00001005",
               o_wr_cnt, o_wr_cyc, o_wr_addr, o_wr_data);
    end
    n_tests++;
    if (o_done_cnt !== 1 || o_done_cyc !== 2 || o_rd_cnt !== 0) begin
      n_fail++;
      $display("FAIL mrc_done got cnt=%0d cyc=%0d rd=%0d want 1/2/0",
               o_done_cnt, o_done_cyc, o_rd_cnt);
    end
  endtask

  task automatic test_cr0_protect();
    bit s, m; logic [31:0] rv;
    rf[3] = 32'hFFFF_FFFF;
    model_apply(32'hEE00_0F10, 3, s, m, rv);
    run_txn(32'hEE00_0F10, 3, 0, 0);
    model_apply(32'hEE10_0F10, 4, s, m, rv);
    run_txn(32'hEE10_0F10, 4, 0, 0);
    n_tests++;
    if (o_wr_cnt !== 1 || o_wr_data !== ID) begin
      n_fail++;
      $display("FAIL cr0_protect got cnt=%0d data=%h want 1/%h",
               o_wr_cnt, o_wr_data, ID);
    end
  endtask

  task automatic test_unsupported();
    run_txn(32'hEE01_0E10, 7, 0, 0);
    n_tests++;
    if (o_done_cnt !== 1 || o_done_cyc !== 1 || o_und !== 1) begin
      n_fail++;
      $display("FAIL und_done got cnt=%0d cyc=%0d und=%b want 1/1/1",
               o_done_cnt, o_done_cyc, o_und);
    end
    n_tests++;
    if (o_rd_cnt !== 0 || o_wr_cnt !== 0) begin
      n_fail++;
      $display("FAIL und_strobes got rd=%0d wr=%0d want 0/0",
               o_rd_cnt, o_wr_cnt);
    end
    run_txn(32'hEE11_0F10, 10, 0, 0);
    n_tests++;
    if (o_wr_data !== mcr[1]) begin
      n_fail++;
      $display("FAIL und_cr1_kept got %h want %h", o_wr_data, mcr[1]);
    end
  endtask

  task automatic test_hold_drop();
    bit s, m; logic [31:0] rv;
    model_apply(32'hEE11_0F10, 11, s, m, rv);
    run_txn(32'hEE11_0F10, 11, 5, 0);
    n_tests++;
    if (o_done_cnt !== 1 || o_wr_cnt !== 1) begin
      n_fail++;
      $display("FAIL hold_single got done=%0d wr=%0d want 1/1",
               o_done_cnt, o_wr_cnt);
    end
    model_apply(32'hEE11_0F10, 11, s, m, rv);
    run_txn(32'hEE11_0F10, 11, 0, 0);
    n_tests++;
    if (o_done_cnt !== 1 || o_wr_data !== rv) begin
      n_fail++;
      $display("FAIL hold_rearm got done=%0d data=%h want 1/%h",
               o_done_cnt, o_wr_data, rv);
    end
  endtask

  task automatic test_early_drop();
    bit s, m; logic [31:0] rv;
    rf[12] = 32'h5A5A_1234;
    model_apply(32'hEE01_0F10, 12, s, m, rv);
    run_txn(32'hEE01_0F10, 12, 0, 1);
    n_tests++;
    if (o_done_cnt !== 1 || o_done_cyc !== 3 || o_cr1 !== mcr[1]) begin
      n_fail++;
      $display("FAIL early_drop got done=%0d cyc=%0d cr1=%h want 1/3/%h",
               o_done_cnt, o_done_cyc, o_cr1, mcr[1]);
    end
  endtask

  task automatic test_reset_mid();
    int dn;
    rf[6] = 32'hABCD_0001;
    word = 32'hEE01_0F10; creg = 6; dav = 1;
    @(posedge clk); #1;
    n_tests++;
    if (rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_rd got %b want 1", rd_en);
    end
    @(posedge clk); #1;
    rdata = rf[6];
    rst = 1;
    @(posedge clk); #1;
    rst = 0; dav = 0;
    model_reset();
    n_tests++;
    if ({done, und, rd_en, wr_en} !== 4'b0 ||
        {rd_addr, wr_addr, wr_data, cr1} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs got %b %h %h %h %h want all 0",
               {done, und, rd_en, wr_en}, rd_addr, wr_addr, wr_data, cr1);
    end
    dn = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    n_tests++;
    if (dn !== 0 || cr1 !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_nodone got done=%0d cr1=%h want 0/0", dn, cr1);
    end
  endtask

  task automatic test_random();
    bit s, m; logic [31:0] rv, w;
    logic [AW-1:0] r;
    int hold, exp_cyc;
    bit early;
    for (int k = 0; k < 60; k++) begin
      w = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        w[27:24] = 4'hE; w[4] = 1'b1; w[11:8] = 4'hF;
      end
      if ($urandom_range(0, 2) == 0) w[19:16] = 4'd1;
      r = AW'($urandom_range(0, 45));
      hold = $urandom_range(0, 3);
      early = ($urandom_range(0, 4) == 0);
      model_apply(w, int'(r), s, m, rv);
      exp_cyc = !s ? 1 : (m ? 2 : 3);
      run_txn(w, r, hold, early);
      n_tests++;
      if (o_done_cnt !== 1 || o_done_cyc !== exp_cyc || o_und !== !s) begin
        n_fail++;
        $display("FAIL rnd_done w=%h got cnt=%0d cyc=%0d und=%b want 1/%0d/%b",
                 w, o_done_cnt, o_done_cyc, o_und, exp_cyc, !s);
      end
      n_tests++;
      if (o_rd_cnt !== int'(s && !m) || o_wr_cnt !== int'(s && m) ||
          o_both !== 0) begin
        n_fail++;
        $display("FAIL rnd_strobes w=%h got rd=%0d wr=%0d both=%b",
                 w, o_rd_cnt, o_wr_cnt, o_both);
      end
      if (s && !m) begin
        n_tests++;
        if (o_rd_addr !== r) begin
          n_fail++;
          $display("FAIL rnd_rd_addr got %0d want %0d", o_rd_addr, r);
        end
      end
      if (s && m) begin
        n_tests++;
        if (o_wr_addr !== r || o_wr_data !== rv) begin
          n_fail++;
          $display("FAIL rnd_wr w=%h got %0d/%h want %0d/%h",
                   w, o_wr_addr, o_wr_data, r, rv);
        end
      end
      n_tests++;
      if (o_cr1 !== mcr[1]) begin
        n_fail++;
        $display("FAIL rnd_cr1 got %h want %h", o_cr1, mcr[1]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 46; i++) rf[i] = $urandom;
    model_reset();
    test_reset();
    test_mcr();
    test_mrc_readback();
    test_cr0_protect();
    test_unsupported();
    test_hold_drop();
    test_early_drop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
